// File: rtl/memory_bus_master.sv
// Bus initiator: turns one CPU load/store request into a timed memory_bus cycle
// with optional bus_ready wait states and a hung-access timeout.
module memory_bus_master #(
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_address,
  input  logic [7:0]  req_data,
  output logic        resp_valid,
  output logic [7:0]  resp_data,
  output logic        resp_error,
  output logic [15:0] address,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in,
  output logic        bus_enable,
  output logic        write_enable,
  input  logic        bus_ready
);

  localparam int          LATENCY       = (READ_LATENCY < 1) ? 1 : READ_LATENCY;
  localparam logic [15:0] LAT_LAST      = 16'(LATENCY - 1);
  localparam logic [7:0]  TIMEOUT_LIMIT = 8'(TIMEOUT);
  localparam bit          TIMEOUT_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic        write_reg, write_next;
  logic [15:0] lat_count_reg, lat_count_next;
  logic [7:0]  wait_count_reg, wait_count_next;
  logic [7:0]  wait_inc;

  logic        req_ready_reg, req_ready_next;
  logic        resp_valid_reg, resp_valid_next;
  logic [7:0]  resp_data_reg, resp_data_next;
  logic        resp_error_reg, resp_error_next;
  logic [15:0] address_reg, address_next;
  logic [7:0]  data_out_reg, data_out_next;
  logic        bus_enable_reg, bus_enable_next;
  logic        write_enable_reg, write_enable_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      write_reg        <= 1'b0;
      lat_count_reg    <= 16'h0000;
      wait_count_reg   <= 8'h00;
      req_ready_reg    <= 1'b1;
      resp_valid_reg   <= 1'b0;
      resp_data_reg    <= 8'h00;
      resp_error_reg   <= 1'b0;
      address_reg      <= 16'h0000;
      data_out_reg     <= 8'h00;
      bus_enable_reg   <= 1'b0;
      write_enable_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      write_reg        <= write_next;
      lat_count_reg    <= lat_count_next;
      wait_count_reg   <= wait_count_next;
      req_ready_reg    <= req_ready_next;
      resp_valid_reg   <= resp_valid_next;
      resp_data_reg    <= resp_data_next;
      resp_error_reg   <= resp_error_next;
      address_reg      <= address_next;
      data_out_reg     <= data_out_next;
      bus_enable_reg   <= bus_enable_next;
      write_enable_reg <= write_enable_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    write_next        = write_reg;
    lat_count_next    = lat_count_reg;
    wait_count_next   = wait_count_reg;
    req_ready_next    = req_ready_reg;
    resp_valid_next   = 1'b0;
    resp_data_next    = resp_data_reg;
    resp_error_next   = resp_error_reg;
    address_next      = address_reg;
    data_out_next     = data_out_reg;
    bus_enable_next   = bus_enable_reg;
    write_enable_next = write_enable_reg;
    wait_inc          = wait_count_reg + 8'd1;

    case (state_reg)
      IDLE: begin
        req_ready_next  = 1'b1;
        bus_enable_next = 1'b0;
        if (req_valid) begin
          write_next        = req_write;
          address_next      = req_address;
          data_out_next     = req_data;
          bus_enable_next   = 1'b1;
          write_enable_next = req_write;
          req_ready_next    = 1'b0;
          lat_count_next    = 16'h0000;
          state_next        = ACCESS;
        end
      end

      ACCESS: begin
        // Writes strobe for exactly one cycle; reads hold the address for the read latency.
        if (write_reg || (lat_count_reg == LAT_LAST)) begin
          write_enable_next = 1'b0;
          wait_count_next   = 8'h00;
          state_next        = WAIT;
        end else begin
          lat_count_next = lat_count_reg + 16'd1;
        end
      end

      WAIT: begin
        // bus_ready is checked first so a ready on the timeout edge still succeeds.
        if (bus_ready) begin
          resp_data_next  = write_reg ? 8'h00 : data_in;
          resp_error_next = 1'b0;
          resp_valid_next = 1'b1;
          bus_enable_next = 1'b0;
          state_next      = DONE;
        end else begin
          if (wait_count_reg != 8'hFF) begin
            wait_count_next = wait_inc;
          end
          if (TIMEOUT_EN && (wait_inc == TIMEOUT_LIMIT)) begin
            resp_data_next  = 8'hFF;
            resp_error_next = 1'b1;
            resp_valid_next = 1'b1;
            bus_enable_next = 1'b0;
            state_next      = DONE;
          end
        end
      end

      DONE: begin
        req_ready_next = 1'b1;
        state_next     = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req_ready    = req_ready_reg;
  assign resp_valid   = resp_valid_reg;
  assign resp_data    = resp_data_reg;
  assign resp_error   = resp_error_reg;
  assign address      = address_reg;
  assign data_out     = data_out_reg;
  assign bus_enable   = bus_enable_reg;
  assign write_enable = write_enable_reg;

endmodule

// File: tb/tb_memory_bus_master.sv
// Randomized self-checking bench for memory_bus_master against a cycle-count model.
module tb_memory_bus_master;

  localparam int RL     = 1;
  localparam int TO     = 12;
  localparam int RL_EFF = (RL < 1) ? 1 : RL;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_address = 16'h0000;
  logic [7:0]  req_data = 8'h00;
  logic [7:0]  data_in = 8'h00;
  logic        bus_ready = 1'b0;
  logic        req_ready, resp_valid, resp_error, bus_enable, write_enable;
  logic [7:0]  resp_data, data_out;
  logic [15:0] address;

  memory_bus_master #(.READ_LATENCY(RL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .address(address), .data_out(data_out), .data_in(data_in),
    .bus_enable(bus_enable), .write_enable(write_enable), .bus_ready(bus_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // expectations from the model
  int         exp_resp_edge, exp_ready_edge, exp_be, exp_we;
  logic [7:0] exp_data;
  logic       exp_err;

  // observations from the last access
  int         obs_resp_edge, obs_ready_edge, obs_be, obs_we, obs_rv;
  logic       obs_entry_ready, obs_accept_ok, obs_stable_bad;
  logic [7:0] obs_data, obs_held_data;
  logic       obs_err, obs_held_err;

  // Edges counted from the accept edge: ACCESS takes a edges, WAIT takes k+1 edges
  // (k low samples then the ready one) unless k reaches TO, which times out after TO edges.
  task automatic predict(input bit wr, input int k, input logic [7:0] din);
    int a, w;
    bit tmo;
    a   = wr ? 1 : RL_EFF;
    tmo = (TO != 0) && (k >= TO);
    w   = tmo ? TO : k + 1;
    exp_resp_edge  = a + w;
    exp_ready_edge = a + w + 1;
    exp_be         = a + w;
    exp_we         = wr ? 1 : 0;
    exp_err        = tmo;
    exp_data       = tmo ? 8'hFF : (wr ? 8'h00 : din);
  endtask

  // Drives one request and records what the bus and response side did, edge by edge.
  task automatic run_access(input bit wr, input logic [15:0] addr, input logic [7:0] wdata,
                            input logic [7:0] din, input int k);
    int a, n;
    a = wr ? 1 : RL_EFF;
    predict(wr, k, din);
    obs_entry_ready = req_ready;
    obs_resp_edge = -1; obs_ready_edge = -1;
    obs_be = 0; obs_we = 0; obs_rv = 0;
    obs_accept_ok = 1'b0; obs_stable_bad = 1'b0;
    obs_data = 8'h00; obs_err = 1'b0; obs_held_data = 8'h00; obs_held_err = 1'b0;
    req_valid = 1'b1; req_write = wr; req_address = addr; req_data = wdata;
    bus_ready = 1'($urandom_range(0, 1));
    data_in = 8'($urandom);
    @(posedge clk);
    n = 0;
    while (1) begin
      #1;
      req_valid   = (n + 1 <= exp_resp_edge) ? 1'($urandom_range(0, 1)) : 1'b0;
      req_write   = 1'($urandom_range(0, 1));
      req_address = 16'($urandom);
      req_data    = 8'($urandom);
      if (n + 1 <= a) bus_ready = 1'($urandom_range(0, 1));
      else            bus_ready = (n + 1 - a > k);
      data_in = (n + 1 == exp_resp_edge && !exp_err && !wr) ? din : 8'($urandom);
      @(negedge clk);
      if (n == 0) obs_accept_ok = !req_ready;
      if (bus_enable) begin
        obs_be++;
        if (address !== addr || data_out !== wdata) obs_stable_bad = 1'b1;
      end
      if (write_enable) begin
        obs_we++;
        if (address !== addr || data_out !== wdata) obs_stable_bad = 1'b1;
      end
      if (resp_valid) begin
        obs_rv++;
        if (obs_resp_edge < 0) begin
          obs_resp_edge = n; obs_data = resp_data; obs_err = resp_error;
        end
      end
      if (n > 0 && req_ready) begin
        obs_ready_edge = n; obs_held_data = resp_data; obs_held_err = resp_error;
        break;
      end
      if (n >= 60) break;
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    bus_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_address = 16'hBEEF; req_data = 8'h5A; bus_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    total++; if (resp_data !== 8'h00) begin bad++; $display("FAIL reset_resp_data: got %h want 00", resp_data); end
    total++; if (resp_error !== 1'b0) begin bad++; $display("FAIL reset_resp_error: got %b want 0", resp_error); end
    total++; if (address !== 16'h0000) begin bad++; $display("FAIL reset_address: got %h want 0000", address); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %h want 00", data_out); end
    total++; if (bus_enable !== 1'b0) begin bad++; $display("FAIL reset_bus_enable: got %b want 0", bus_enable); end
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL reset_write_enable: got %b want 0", write_enable); end
    req_valid = 1'b0; bus_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    $display("txn reset: outputs checked");
  endtask

  task automatic test_read();
    run_access(1'b0, 16'h0005, 8'($urandom), 8'h3C, 0);
    $display("txn read: addr=0005 resp=%h err=%0d edge=%0d", obs_data, obs_err, obs_resp_edge);
    total++; if (obs_entry_ready !== 1'b1) begin bad++; $display("FAIL read_entry_ready: got %b want 1", obs_entry_ready); end
    total++; if (obs_accept_ok !== 1'b1) begin bad++; $display("FAIL read_accept: req_ready after accept got %b want 0", !obs_accept_ok); end
    total++; if (obs_resp_edge != exp_resp_edge) begin bad++; $display("FAIL read_resp_edge: got %0d want %0d", obs_resp_edge, exp_resp_edge); end
    total++; if (obs_data !== exp_data) begin bad++; $display("FAIL read_data: got %h want %h", obs_data, exp_data); end
    total++; if (obs_err !== exp_err) begin bad++; $display("FAIL read_err: got %b want %b", obs_err, exp_err); end
    total++; if (obs_be != exp_be) begin bad++; $display("FAIL read_be_cycles: got %0d want %0d", obs_be, exp_be); end
    total++; if (obs_we != exp_we) begin bad++; $display("FAIL read_we_cycles: got %0d want %0d", obs_we, exp_we); end
    total++; if (obs_rv != 1) begin bad++; $display("FAIL read_resp_pulses: got %0d want 1", obs_rv); end
  endtask

  task automatic test_write();
    run_access(1'b1, 16'hC010, 8'hA5, 8'h00, 0);
    $display("txn write: addr=C010 data=A5 resp=%h err=%0d ready_edge=%0d", obs_data, obs_err, obs_ready_edge);
    total++; if (obs_we != exp_we) begin bad++; $display("FAIL write_we_cycles: got %0d want %0d", obs_we, exp_we); end
    total++; if (obs_stable_bad !== 1'b0) begin bad++; $display("FAIL write_bus_stable: got unstable=%b want 0", obs_stable_bad); end
    total++; if (obs_data !== exp_data) begin bad++; $display("FAIL write_resp_data: got %h want %h", obs_data, exp_data); end
    total++; if (obs_ready_edge != exp_ready_edge) begin bad++; $display("FAIL write_ready_edge: got %0d want %0d", obs_ready_edge, exp_ready_edge); end
  endtask

  task automatic test_stall();
    run_access(1'b0, 16'($urandom), 8'($urandom), 8'h77, 10);
    $display("txn stall: k=10 resp=%h err=%0d edge=%0d", obs_data, obs_err, obs_resp_edge);
    total++; if (obs_resp_edge != exp_resp_edge) begin bad++; $display("FAIL stall_resp_edge: got %0d want %0d", obs_resp_edge, exp_resp_edge); end
    total++; if (obs_data !== exp_data) begin bad++; $display("FAIL stall_data: got %h want %h", obs_data, exp_data); end
    total++; if (obs_stable_bad !== 1'b0) begin bad++; $display("FAIL stall_addr_stable: got unstable=%b want 0", obs_stable_bad); end
    total++; if (obs_be != exp_be) begin bad++; $display("FAIL stall_be_cycles: got %0d want %0d", obs_be, exp_be); end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    run_access(1'b0, 16'($urandom), 8'($urandom), 8'h11, TO + 5);
    $display("txn timeout: resp=%h err=%0d edge=%0d", obs_data, obs_err, obs_resp_edge);
    total++; if (obs_resp_edge != exp_resp_edge) begin bad++; $display("FAIL timeout_edge: got %0d want %0d", obs_resp_edge, exp_resp_edge); end
    total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", obs_err); end
    total++; if (obs_data !== 8'hFF) begin bad++; $display("FAIL timeout_data: got %h want ff", obs_data); end
    total++; if (obs_held_err !== 1'b1) begin bad++; $display("FAIL timeout_err_held: got %b want 1", obs_held_err); end
    d = 8'($urandom);
    run_access(1'b0, 16'($urandom), 8'($urandom), d, 0);
    $display("txn after_timeout: resp=%h err=%0d", obs_data, obs_err);
    total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL clear_err: got %b want 0", obs_err); end
    total++; if (obs_data !== d) begin bad++; $display("FAIL clear_data: got %h want %h", obs_data, d); end
    d = 8'($urandom);
    run_access(1'b0, 16'($urandom), 8'($urandom), d, TO - 1);
    $display("txn ready_on_limit: resp=%h err=%0d edge=%0d", obs_data, obs_err, obs_resp_edge);
    total++; if (obs_err !== exp_err) begin bad++; $display("FAIL ready_wins_err: got %b want %b", obs_err, exp_err); end
    total++; if (obs_data !== exp_data) begin bad++; $display("FAIL ready_wins_data: got %h want %h", obs_data, exp_data); end
    total++; if (obs_resp_edge != exp_resp_edge) begin bad++; $display("FAIL ready_wins_edge: got %0d want %0d", obs_resp_edge, exp_resp_edge); end
    run_access(1'b1, 16'($urandom), 8'($urandom), 8'h00, TO);
    $display("txn write_timeout: resp=%h err=%0d", obs_data, obs_err);
    total++; if (obs_err !== exp_err || obs_data !== exp_data) begin
      bad++; $display("FAIL write_timeout: got err=%b data=%h want err=%b data=%h", obs_err, obs_data, exp_err, exp_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a0, cur;
    logic moved;
    int n, ready_n;
    bit got;
    a0 = 16'($urandom);
    cur = a0; moved = 1'b0; ready_n = -1; got = 0;
    predict(1'b0, 0, 8'h00);
    req_valid = 1'b1; req_write = 1'b0; req_address = a0; req_data = 8'($urandom);
    bus_ready = 1'b1; data_in = 8'($urandom);
    @(posedge clk);
    n = 0;
    while (n < 20 && !got) begin
      #1;
      cur = 16'($urandom);
      req_address = cur;
      @(negedge clk);
      if (bus_enable && address !== a0) moved = 1'b1;
      if (n > 0 && req_ready) begin
        ready_n = n;
        @(negedge clk);
        got = 1;
        total++; if (address !== cur) begin bad++; $display("FAIL b2b_second_addr: got %h want %h", address, cur); end
        total++; if (bus_enable !== 1'b1 || req_ready !== 1'b0) begin
          bad++; $display("FAIL b2b_second_accept: got be=%b rdy=%b want be=1 rdy=0", bus_enable, req_ready);
        end
      end else begin
        @(posedge clk);
        n++;
      end
    end
    $display("txn back_to_back: first=%h second=%h ready_edge=%0d", a0, cur, ready_n);
    total++; if (ready_n != exp_ready_edge) begin bad++; $display("FAIL b2b_ready_edge: got %0d want %0d", ready_n, exp_ready_edge); end
    total++; if (moved !== 1'b0) begin bad++; $display("FAIL b2b_first_addr_stable: got moved=%b want 0", moved); end
    #1; req_valid = 1'b0;
    n = 0;
    while (n < 40 && !req_ready) begin @(negedge clk); n++; end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_drain: got req_ready=%b want 1", req_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    bit wr;
    int k;
    logic [15:0] ad;
    logic [7:0] wd, din;
    int ks[8] = '{0, 1, 2, 3, 10, TO - 1, TO, TO + 3};
    for (int t = 0; t < 24; t++) begin
      wr = 1'($urandom_range(0, 1));
      ad = 16'($urandom); wd = 8'($urandom); din = 8'($urandom);
      k = ks[$urandom_range(0, 7)];
      run_access(wr, ad, wd, din, k);
      $display("txn rand %0d: wr=%0d addr=%h wdata=%h k=%0d resp=%h err=%0d edge=%0d",
               t, wr, ad, wd, k, obs_data, obs_err, obs_resp_edge);
      total++; if (obs_resp_edge != exp_resp_edge) begin bad++; $display("FAIL rand_resp_edge: got %0d want %0d", obs_resp_edge, exp_resp_edge); end
      total++; if (obs_ready_edge != exp_ready_edge) begin bad++; $display("FAIL rand_ready_edge: got %0d want %0d", obs_ready_edge, exp_ready_edge); end
      total++; if (obs_data !== exp_data) begin bad++; $display("FAIL rand_data: got %h want %h", obs_data, exp_data); end
      total++; if (obs_err !== exp_err) begin bad++; $display("FAIL rand_err: got %b want %b", obs_err, exp_err); end
      total++; if (obs_held_data !== exp_data) begin bad++; $display("FAIL rand_data_held: got %h want %h", obs_held_data, exp_data); end
      total++; if (obs_be != exp_be) begin bad++; $display("FAIL rand_be_cycles: got %0d want %0d", obs_be, exp_be); end
      total++; if (obs_we != exp_we) begin bad++; $display("FAIL rand_we_cycles: got %0d want %0d", obs_we, exp_we); end
      total++; if (obs_rv != 1) begin bad++; $display("FAIL rand_resp_pulses: got %0d want 1", obs_rv); end
      total++; if (obs_stable_bad !== 1'b0) begin bad++; $display("FAIL rand_bus_stable: got unstable=%b want 0", obs_stable_bad); end
      total++; if (obs_accept_ok !== 1'b1) begin bad++; $display("FAIL rand_accept: req_ready after accept got %b want 0", !obs_accept_ok); end
    end
  endtask

  task automatic test_reset_mid();
    int rv;
    req_valid = 1'b1; req_write = 1'b0; req_address = 16'($urandom); req_data = 8'($urandom);
    bus_ready = 1'b0;
    @(posedge clk);
    #1; req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus_enable !== 1'b0) begin bad++; $display("FAIL midreset_bus_enable: got %b want 0", bus_enable); end
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL midreset_write_enable: got %b want 0", write_enable); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midreset_req_ready: got %b want 1", req_ready); end
    bus_ready = 1'b1;
    rv = 0;
    repeat (2) begin @(negedge clk); if (resp_valid) rv++; end
    reset = 1'b1;
    repeat (6) begin @(negedge clk); if (resp_valid) rv++; end
    $display("txn reset_mid: resp pulses after reset=%0d", rv);
    total++; if (rv != 0) begin bad++; $display("FAIL midreset_no_resp: got %0d pulses want 0", rv); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL midreset_idle: got req_ready=%b want 1", req_ready); end
    @(posedge clk);
    #1;
    run_access(1'b1, 16'($urandom), 8'($urandom), 8'h00, 1);
    $display("txn post_reset_write: resp=%h edge=%0d", obs_data, obs_resp_edge);
    total++; if (obs_resp_edge != exp_resp_edge || obs_we != exp_we) begin
      bad++; $display("FAIL post_reset_write: got edge=%0d we=%0d want edge=%0d we=%0d", obs_resp_edge, obs_we, exp_resp_edge, exp_we);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_stall();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
